mem_bus_arbiter: RTL

Two-client arbiter between the L1 caches (client 0 = instruction cache, client 1 = data cache) and the single memory-side system bus. It grants one client at a time, forwards that client's read request to memory, then routes the full BEATS-beat response burst back to the owner. Each client sees the same reqcyc/reqack/respcyc/respack protocol it would see talking directly to memory.

---
 rtl/bus_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: arbiter states and the default bus geometry
// that the cache and the arbiter agree on.
package bus_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int TAG_WIDTH  = 13;
  localparam int LINE_BEATS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic [1:0] client_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins outright; on a tie the
// client that was not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the I-cache (client 0) and D-cache (client 1) onto the single
// memory bus and routes each BEATS-long response burst back to its owner.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = DATA_WIDTH,
  parameter int BUS_TAG_WIDTH  = TAG_WIDTH,
  parameter int BEATS          = LINE_BEATS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  c_bus_reqcyc,
  output logic [1:0]                  c_bus_reqack,
  input  logic [2*BUS_DATA_WIDTH-1:0] c_bus_req,
  input  logic [2*BUS_TAG_WIDTH-1:0]  c_bus_reqtag,
  output logic [1:0]                  c_bus_respcyc,
  input  logic [1:0]                  c_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0]   c_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]    c_bus_resptag,
  output logic                        m_bus_reqcyc,
  input  logic                        m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]   m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    m_bus_reqtag,
  input  logic                        m_bus_respcyc,
  output logic                        m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]   m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    m_bus_resptag,
  output logic [1:0]                  dbg_state
);

  // Handshakes: a request transfers on a cycle where reqcyc && reqack, a
  // response beat on a cycle where respcyc && respack. Valids are held until
  // that cycle; acks only count while the matching valid is high.

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t                state;
  logic                      owner;
  logic                      last_grant;
  logic [CNT_W-1:0]          beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;

  logic                      grant_valid;
  logic                      grant_idx;
  logic                      beat_done;
  logic [BUS_DATA_WIDTH-1:0] win_addr;
  logic [BUS_TAG_WIDTH-1:0]  win_tag;

  rr_arbiter2 u_rr (
    .req         (c_bus_reqcyc),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_addr  = grant_idx ? c_bus_req[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                               : c_bus_req[BUS_DATA_WIDTH-1:0];
  assign win_tag   = grant_idx ? c_bus_reqtag[2*BUS_TAG_WIDTH-1:BUS_TAG_WIDTH]
                               : c_bus_reqtag[BUS_TAG_WIDTH-1:0];
  assign beat_done = (state == RESP) && m_bus_respcyc && c_bus_respack[owner];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner  <= grant_idx;
            addr_q <= win_addr;
            tag_q  <= win_tag;
            state  <= REQ;
          end
        end
        REQ: begin
          if (m_bus_reqack) begin
            last_grant <= owner;
            beat_cnt   <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (beat_done) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so nothing leaks while the registers clear.
  always_comb begin
    c_bus_reqack  = 2'b00;
    c_bus_respcyc = 2'b00;
    c_bus_resp    = '0;
    c_bus_resptag = '0;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    if (!reset) begin
      case (state)
        REQ: begin
          m_bus_reqcyc = 1'b1;
          m_bus_req    = addr_q;
          m_bus_reqtag = tag_q;
          c_bus_reqack = m_bus_reqack ? client_mask(owner) : 2'b00;
        end
        RESP: begin
          c_bus_respcyc = m_bus_respcyc ? client_mask(owner) : 2'b00;
          c_bus_resp    = m_bus_resp;
          c_bus_resptag = m_bus_resptag;
          m_bus_respack = c_bus_respack[owner];
        end
        default: ;
      endcase
    end
  end

endmodule
